div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU. Sits in EX, downstream of the

---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state codes and control constants for the divider.
package div_unit_pkg;

  // Divider FSM state codes (2 bits).
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_END  = 2'b10
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  // Trial subtraction; keep the difference only when it does not go negative.
  always_comb begin
    shifted  = {rem, dbit};
    diff     = shifted[WIDTH:0] - {1'b0, divisor};
    qbit     = (shifted >= {2'b00, divisor});
    rem_next = qbit ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Delivers {HI=remainder, LO=quotient} with a one-cycle ready pulse and
// requests a pipeline stall while iterating.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle
// with result {opdata1, all-ones}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  div_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-2:0] quo;
  logic             qbit;
  logic             sign_q;
  logic             sign_r;
  logic             go;
  logic             last_step;
  logic             zero_div;

  // Two's-complement magnitude, only when the operand is treated as signed.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (en && (sv < 0)) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Conditional negation applied to the unsigned quotient/remainder.
  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign go        = (state == DIV_IDLE) && (start == DIV_START) && !annul;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign stall_req = go || (state == DIV_ON);
  assign ready     = ((state == DIV_END) && !annul) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
`ifdef DIV_ZERO_FAST_EN
  assign zero_div  = (opdata2 == '0);
`else
  assign zero_div  = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dbit     (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; annul wins over everything, including start.
  always_comb begin
    state_n = state;
    if (annul) begin
      state_n = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start == DIV_START) state_n = zero_div ? DIV_END : DIV_ON;
        DIV_ON:   if (last_step) state_n = DIV_END;
        DIV_END:  state_n = DIV_IDLE;
        default:  state_n = DIV_IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      result <= '0;
    end else if (!annul) begin
      if (go) begin
        cnt    <= '0;
        rem    <= '0;
        quo    <= '0;
        dvd    <= abs_val(opdata1, signed_div);
        dvs    <= abs_val(opdata2, signed_div);
        sign_q <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
        sign_r <= signed_div && opdata1[WIDTH-1];
        if (zero_div) result <= {opdata1, {WIDTH{1'b1}}};
      end else if (state == DIV_ON) begin
        cnt <= cnt + CNT_W'(1);
        dvd <= {dvd[WIDTH-2:0], 1'b0};
        rem <= rem_next;
        quo <= {quo[WIDTH-3:0], qbit};
        if (last_step)
          result <= {fix_sign(rem_next[WIDTH-1:0], sign_r), fix_sign({quo, qbit}, sign_q)};
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized scoreboard bench for div_unit with a plain
// arithmetic reference model; honours DIV_ZERO_FAST_EN when defined.
module tb_div_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic           annul;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall_req;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] last_res;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sg, output bit chk, output int lat);
    longint sa, sb, q, r;
    chk = 1'b1;
    lat = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 0) begin
      lat = 1;
      return {a, 32'hFFFFFFFF};
    end
`endif
    if (!sg) begin
      if (b == 0) return {a, 32'hFFFFFFFF};
      return {a % b, a / b};
    end
    if (b == 0) begin
      chk = 1'b0;
      return '0;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk) check("result", result, e.res);
      end
    end
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [63:0] r;
    bit          chk;
    int          lat;
    int          n;
    bit          got;
    r = model(a, b, sg, chk, lat);
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sg;
    opdata1    = a;
    opdata2    = b;
    n          = cyc;
    sbq.push_back('{r, n + lat, chk});
    if (chk) last_res = r;
    got = 1'b0;
    for (int k = 0; k <= 40 && !got; k++) begin
      @(negedge clk);
      check("stall_req", 64'(stall_req), 64'(k < lat));
      if (ready) begin
        got   = 1'b1;
        start = 1'b0;
      end else if (k == 0) begin
        @(posedge clk); #1;
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout: no ready for %h/%h got none required cycle %0d", a, b, n + lat);
      start = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sg;
    int          sel;
    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    last_res   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_div(32'd100, 32'd7, 1'b0);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1);
    do_div(32'd7, 32'hFFFFFFFE, 1'b1);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
    do_div(32'h12345678, 32'd0, 1'b0);
    do_div(32'd0, 32'd5, 1'b0);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0);
    do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_div(32'h80000000, 32'd0, 1'b1);
    do_div(32'd100, 32'd7, 1'b0);

    // Annul mid-divide: back to idle, no ready, result untouched.
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd5000;
    opdata2    = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("annul_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("annul_stall", 64'(stall_req), 64'd0);
      check("annul_result", result, last_res);
    end
    do_div(32'd5000, 32'd3, 1'b0);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b1;
    opdata1    = 32'hFFFFFC18;
    opdata2    = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst_result", result, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_div(32'hFFFFFC18, 32'd7, 1'b1);

    // Randomized operands, biased toward boundary divisors and dividends.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      a   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'h80000000;
        default: b = 32'($urandom);
      endcase
      sg = 1'($urandom_range(0, 1));
      do_div(a, b, sg);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
